psum_write_ctrl: RTL
====================

// Module: psum_write_ctrl
// PURPOSE
//   Write-back stage downstream of the main controller's WRITE_REQ/WAIT_FOR_WRITE states.
//   Latches a result on write_req and, in psum mode, adds the partial sum read from the psum buffer.
//   Writes the value into the output psum buffer through a circular write pointer.
//   Returns a 2-bit stall code that the main controller samples every cycle while waiting.
// PARAMETERS
//   DATA_WIDTH  16  width of result/psum data (two's complement)
//   ADDR_WIDTH  4   output buffer address width
//   DEPTH       16  entries before FULL (must be <= 2**ADDR_WIDTH)
// PORTS
//   clk           in   1    clock, rising edge
//   reset         in   1    asynchronous, active-high
//   global_rst    in   1    synchronous clear, same effect as reset
//   write_req     in   1    1-cycle request (main controller 'done')
//   result_data   in   DW   value to write; sampled with write_req
//   psum_mode     in   1    1: accumulate with psum_rdata; sampled with write_req
//   psum_rdata    in   DW   partial sum from psum buffer
//   psum_rvalid   in   1    psum_rdata valid this cycle
//   buf_ready     in   1    output buffer accepts a write this cycle
//   buf_wen       out  1    write strobe, 1 cycle per accepted write
//   buf_waddr     out  AW   write address
//   buf_wdata     out  DW   write data
//   stall         out  2    00 busy/idle, 10 write done, 11 buffer full
//   wr_count      out  AW+1 writes since reset/global_rst
//   overflow      out  1    sticky; set when an addition overflows DW bits
//   protocol_err  out  1    sticky; set when write_req arrives while not IDLE
// BEHAVIOUR
//   Reset/global_rst: state IDLE; waddr, wr_count, data_r=0; stall=00; buf_wen=0; overflow=0; protocol_err=0.
//   global_rst has priority over all other inputs in the same cycle.
//   States: IDLE, WAIT_PSUM, WRITE, ACK, FULL.
//   IDLE: stall=00. On write_req: data_r<=result_data.
//     psum_mode=1 -> WAIT_PSUM; psum_mode=0 -> WRITE.
//   WAIT_PSUM: stall=00. On psum_rvalid: data_r<=data_r+psum_rdata (signed), then -> WRITE.
//     Otherwise wait indefinitely.
//   WRITE: stall=00. If buf_ready: buf_wen=1 (combinational, same cycle), buf_waddr=waddr, buf_wdata=data_r.
//     On that edge waddr advances and wr_count increments.
//     Next state: FULL if the new wr_count==DEPTH, else ACK. If buf_ready=0: hold, buf_wen=0.
//   ACK: stall=10 for exactly 1 cycle, then -> IDLE.
//   FULL: stall=11 held until reset/global_rst. write_req is ignored and sets protocol_err.
//   waddr wraps DEPTH-1 -> 0. wr_count saturates at DEPTH.
//   write_req in any state other than IDLE: request dropped, protocol_err<=1, no other effect.
//   Latency, psum_mode=0, buf_ready=1: write_req @N -> buf_wen @N+1 -> stall=10 @N+2.
//   psum_mode=1 adds (cycles in WAIT_PSUM) to that latency.
//   Overflow is detected when the operand signs match and the sum sign differs; it sets overflow.
//   buf_waddr/buf_wdata are driven from registers in every state; only buf_wen qualifies them.
// CONFIGURATION
//   PSUM_SAT_EN defined: on overflow, the sum saturates to +2^(DW-1)-1 or -2^(DW-1).
//   Not defined: the sum wraps modulo 2^DW.
//   overflow is flagged in both builds.
// TESTING
//   write_req, result=0x0005, psum_mode=0, buf_ready=1 -> buf_wen@+1 addr0 data0x0005; stall=10@+2 only; wr_count=1.
//   psum_mode=1, result=3, psum_rdata=-7 with rvalid 2 cycles late -> wdata=0xFFFC; stall=10 at +4.
//   DW=16, result=0x7FFF, psum=0x0001 -> overflow=1; wdata=0x7FFF with PSUM_SAT_EN, 0x8000 without.
//   DEPTH=16: 16 writes -> 16th write gives stall=11 (no 10), held; a 17th write_req sets protocol_err, no buf_wen.
//   buf_ready low 5 cycles in WRITE -> no buf_wen, stall=00 throughout; write occurs the cycle buf_ready rises.
//   global_rst asserted in WAIT_PSUM or FULL -> next cycle IDLE, waddr=0, wr_count=0, stall=00, flags cleared.

Source files
------------

// File: rtl/psum_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// psum_write_ctrl_if
//   Bundles the request, psum-read, output-buffer and status signals of the
//   partial-sum write-back stage.
//   master : upstream controller / environment side (drives requests, psum
//            data and buffer readiness; observes write strobe and status)
//   slave  : the write-back stage itself
// Signals
//   write_req, result_data, psum_mode      request and its payload
//   psum_rdata, psum_rvalid                partial sum from the psum buffer
//   buf_ready                              output buffer can accept a write
//   buf_wen, buf_waddr, buf_wdata          output buffer write port
//   stall                                  00 busy/idle, 10 done, 11 full
//   wr_count, overflow, protocol_err       status / sticky error flags
// ---------------------------------------------------------------------------
interface psum_write_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  write_req;
  logic [DATA_WIDTH-1:0] result_data;
  logic                  psum_mode;
  logic [DATA_WIDTH-1:0] psum_rdata;
  logic                  psum_rvalid;
  logic                  buf_ready;
  logic                  buf_wen;
  logic [ADDR_WIDTH-1:0] buf_waddr;
  logic [DATA_WIDTH-1:0] buf_wdata;
  logic [1:0]            stall;
  logic [ADDR_WIDTH:0]   wr_count;
  logic                  overflow;
  logic                  protocol_err;

  modport master (
    output write_req, result_data, psum_mode, psum_rdata, psum_rvalid, buf_ready,
    input  buf_wen, buf_waddr, buf_wdata, stall, wr_count, overflow, protocol_err
  );

  modport slave (
    input  write_req, result_data, psum_mode, psum_rdata, psum_rvalid, buf_ready,
    output buf_wen, buf_waddr, buf_wdata, stall, wr_count, overflow, protocol_err
  );
endinterface

// File: rtl/psum_write_ctrl.sv
// ---------------------------------------------------------------------------
// psum_write_ctrl
//   Write-back stage behind the main controller. Latches a result on
//   write_req, optionally accumulates the partial sum read from the psum
//   buffer, writes the value into the output buffer through a circular write
//   pointer and reports a 2-bit stall code (00 busy/idle, 10 write done,
//   11 buffer full).
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   global_rst  synchronous clear with the same effect as reset; wins over
//               every other input in the same cycle
//   bus         psum_write_ctrl_if.slave (request, psum, buffer, status)
// Configuration
//   PSUM_SAT_EN  defined: an overflowing accumulation saturates to the most
//                positive / most negative value. Undefined: it wraps.
//                The overflow flag is set in both builds.
// ---------------------------------------------------------------------------
module psum_write_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             global_rst,
  psum_write_ctrl_if.slave bus
);
  localparam int MSB = DATA_WIDTH - 1;
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PSUM,
    S_WRITE,
    S_ACK,
    S_FULL
  } state_t;

  state_t                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_data, w_data_next;
  logic [ADDR_WIDTH-1:0] r_waddr, w_waddr_next;
  logic [ADDR_WIDTH:0]   r_wr_count, w_wr_count_next;
  logic                  r_overflow, w_overflow_next;
  logic                  r_protocol_err, w_protocol_err_next;

  logic [DATA_WIDTH-1:0] w_sum_raw;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_sum_ovf;
  logic [ADDR_WIDTH:0]   w_count_inc;
  logic                  w_buf_wen;
  logic [1:0]            w_stall;

  // Signed overflow: operands agree in sign but the truncated sum does not.
  assign w_sum_raw = r_data + bus.psum_rdata;
  assign w_sum_ovf = (r_data[MSB] == bus.psum_rdata[MSB]) && (w_sum_raw[MSB] != r_data[MSB]);

`ifdef PSUM_SAT_EN
  localparam logic [DATA_WIDTH-1:0] LP_POS_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] LP_NEG_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
  // On overflow both operands share the sign, so r_data's sign picks the rail.
  assign w_sum = w_sum_ovf ? (r_data[MSB] ? LP_NEG_MIN : LP_POS_MAX) : w_sum_raw;
`else
  assign w_sum = w_sum_raw;
`endif

  // Count saturates at DEPTH; in practice FULL blocks further writes anyway.
  assign w_count_inc = (r_wr_count == LP_DEPTH_CNT) ? r_wr_count : r_wr_count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_data         <= '0;
      r_waddr        <= '0;
      r_wr_count     <= '0;
      r_overflow     <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_data         <= w_data_next;
      r_waddr        <= w_waddr_next;
      r_wr_count     <= w_wr_count_next;
      r_overflow     <= w_overflow_next;
      r_protocol_err <= w_protocol_err_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_data_next         = r_data;
    w_waddr_next        = r_waddr;
    w_wr_count_next     = r_wr_count;
    w_overflow_next     = r_overflow;
    w_protocol_err_next = r_protocol_err;
    w_buf_wen           = 1'b0;
    w_stall             = 2'b00;

    // A request outside IDLE is dropped; only the sticky flag records it.
    if (bus.write_req && (r_state != S_IDLE)) begin
      w_protocol_err_next = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.write_req) begin
          w_data_next  = bus.result_data;
          w_state_next = bus.psum_mode ? S_WAIT_PSUM : S_WRITE;
        end
      end
      S_WAIT_PSUM: begin
        if (bus.psum_rvalid) begin
          w_data_next     = w_sum;
          w_overflow_next = r_overflow | w_sum_ovf;
          w_state_next    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.buf_ready) begin
          w_buf_wen       = 1'b1;
          w_waddr_next    = (r_waddr == LP_LAST_ADDR) ? '0 : r_waddr + 1'b1;
          w_wr_count_next = w_count_inc;
          w_state_next    = (w_count_inc == LP_DEPTH_CNT) ? S_FULL : S_ACK;
        end
      end
      S_ACK: begin
        w_stall      = 2'b10;
        w_state_next = S_IDLE;
      end
      S_FULL: begin
        w_stall = 2'b11;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Synchronous clear overrides everything, including a same-cycle write.
    if (global_rst) begin
      w_state_next        = S_IDLE;
      w_data_next         = '0;
      w_waddr_next        = '0;
      w_wr_count_next     = '0;
      w_overflow_next     = 1'b0;
      w_protocol_err_next = 1'b0;
      w_buf_wen           = 1'b0;
    end
  end

  assign bus.buf_wen      = w_buf_wen;
  assign bus.buf_waddr    = r_waddr;
  assign bus.buf_wdata    = r_data;
  assign bus.stall        = w_stall;
  assign bus.wr_count     = r_wr_count;
  assign bus.overflow     = r_overflow;
  assign bus.protocol_err = r_protocol_err;
endmodule
